// File: rtl/group_pkg.sv
// Shared helpers for the signed reduction blocks: tree sizing and
// clamping a wide signed sum into a narrower two's-complement range.
package group_pkg;

    localparam int SAT_WRAP  = 0;
    localparam int SAT_CLAMP = 1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Number of elements present after lvl halvings of an n-element group.
    function automatic int level_count(input int n, input int lvl);
        int c;
        c = n;
        for (int i = 0; i < 32; i++) begin
            if (i < lvl) begin
                c = (c + 1) / 2;
            end
        end
        return c;
    endfunction

    // Result occupies the low width bits of the returned word.
    function automatic logic [31:0] sat_to_width(input logic signed [63:0] value,
                                                 input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (value > hi) begin
            return hi[31:0];
        end
        if (value < lo) begin
            return lo[31:0];
        end
        return value[31:0];
    endfunction

endpackage

// File: rtl/group_add_level.sv
// One registered level of the adder tree: adjacent pairs are summed,
// an odd trailing element is carried forward unchanged.
module group_add_level #(
    parameter int N = 2,
    parameter int W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       in_val,
    input  logic [N*W-1:0]             in_data,
    output logic                       out_val,
    output logic [((N+1)/2)*W-1:0]     out_data
);

    localparam int M = (N + 1) / 2;

    logic val_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_q <= 1'b0;
        end else if (en) begin
            val_q <= in_val;
        end
    end

    assign out_val = val_q;

    for (genvar gi = 0; gi < M; gi++) begin : g_node
        logic [W-1:0] node_d;
        logic [W-1:0] node_q;

        if (2 * gi + 1 < N) begin : g_pair
            assign node_d = in_data[2*gi*W +: W] + in_data[(2*gi+1)*W +: W];
        end else begin : g_pass
            assign node_d = in_data[2*gi*W +: W];
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                node_q <= '0;
            end else if (en) begin
                node_q <= node_d;
            end
        end

        assign out_data[gi*W +: W] = node_q;
    end

endmodule

// File: rtl/group_add_tree.sv
// Pipelined signed sum of GROUP_NB operands: input register, log2 adder
// levels at widened precision, then a wrap/clamp output register.
module group_add_tree
    import group_pkg::*;
#(
    parameter int GROUP_NB  = 4,
    parameter int NUM_WIDTH = 16,
    parameter int SATURATE  = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_WIDTH*GROUP_NB-1:0] up_data,
    input  logic                          up_val,
    output logic                          up_rdy,
    output logic [NUM_WIDTH-1:0]          dn_data,
    output logic                          dn_val,
    input  logic                          dn_rdy
);

    localparam int LV = clog2(GROUP_NB);
    localparam int IW = NUM_WIDTH + LV;
    localparam int BW = GROUP_NB * IW;

    if (GROUP_NB < 1 || GROUP_NB > 16 || NUM_WIDTH < 2 || NUM_WIDTH > 32) begin : g_param_check
        $error("group_add_tree: GROUP_NB must be 1..16 and NUM_WIDTH 2..32");
    end

    logic en;
    logic [BW-1:0] in_d;
    logic [BW-1:0] in_q;
    logic          in_val_q;
    logic [BW-1:0] lvl_data [LV+1];
    logic          lvl_val  [LV+1];
    logic [LV:0]   lvl_par;

    // One stall signal for every stage keeps bubbles in place.
    assign en     = !dn_val || dn_rdy;
    assign up_rdy = en;

    for (genvar gi = 0; gi < GROUP_NB; gi++) begin : g_sext
        assign in_d[gi*IW +: IW] = IW'($signed(up_data[gi*NUM_WIDTH +: NUM_WIDTH]));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_q     <= '0;
            in_val_q <= 1'b0;
        end else if (en) begin
            in_q     <= in_d;
            in_val_q <= up_val;
        end
    end

    assign lvl_data[0] = in_q;
    assign lvl_val[0]  = in_val_q;

    for (genvar gi = 1; gi <= LV; gi++) begin : g_level
        localparam int NI = level_count(GROUP_NB, gi - 1);
        localparam int NO = level_count(GROUP_NB, gi);
        logic [NO*IW-1:0] lvl_out;

        group_add_level #(
            .N (NI),
            .W (IW)
        ) u_level (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .in_val   (lvl_val[gi-1]),
            .in_data  (lvl_data[gi-1][NI*IW-1:0]),
            .out_val  (lvl_val[gi]),
            .out_data (lvl_out)
        );

        assign lvl_data[gi] = BW'(lvl_out);
    end

    // Rows are only partially populated; the padding is constant zero.
    for (genvar gi = 0; gi <= LV; gi++) begin : g_par
        assign lvl_par[gi] = ^lvl_data[gi];
    end

    logic signed [IW-1:0]  tree_sum;
    logic [31:0]           sat_full;
    logic [NUM_WIDTH-1:0]  out_d;
    logic [NUM_WIDTH-1:0]  out_q;
    logic                  out_val_q;
    logic                  unused_bits;

    assign tree_sum    = lvl_data[LV][IW-1:0];
    assign sat_full    = sat_to_width(64'(tree_sum), NUM_WIDTH);
    assign out_d       = (SATURATE == SAT_CLAMP) ? sat_full[NUM_WIDTH-1:0]
                                                 : tree_sum[NUM_WIDTH-1:0];
    assign unused_bits = ^{sat_full, lvl_par};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q     <= '0;
            out_val_q <= 1'b0;
        end else if (en) begin
            out_q     <= out_d;
            out_val_q <= lvl_val[LV];
        end
    end

    assign dn_data = out_q;
    assign dn_val  = out_val_q;

endmodule

// File: tb/tb_group_add_tree.sv
// Bench for group_add_tree: every GROUP_NB 1..16 in both output modes at
// NUM_WIDTH=8, fed one shared stream and scored against an integer model.
module tb_group_add_tree;

    localparam int NI = 32;

    logic         clk;
    logic         rst;
    logic [127:0] up_data;
    logic         up_val;
    logic         dn_rdy;
    logic         up_rdy_a  [NI];
    logic [7:0]   dn_data_a [NI];
    logic         dn_val_a  [NI];

    int checks = 0;
    int errors = 0;

    int   exp_mem [NI][64];
    int   head    [NI];
    int   tail    [NI];
    int   in_cnt  [NI];
    int   out_cnt [NI];
    bit   stall_prev [NI];
    logic [7:0] held [NI];

    int   lat [NI];
    logic [7:0] res [NI];

    bit   collect = 0;
    int   bp_n    = 0;
    int   bp_out  [16];

    for (genvar gi = 1; gi <= 16; gi++) begin : g_grp
        for (genvar si = 0; si < 2; si++) begin : g_mode
            group_add_tree #(
                .GROUP_NB  (gi),
                .NUM_WIDTH (8),
                .SATURATE  (si)
            ) u_dut (
                .clk     (clk),
                .rst     (rst),
                .up_data (up_data[gi*8-1:0]),
                .up_val  (up_val),
                .up_rdy  (up_rdy_a[(gi-1)*2+si]),
                .dn_data (dn_data_a[(gi-1)*2+si]),
                .dn_val  (dn_val_a[(gi-1)*2+si]),
                .dn_rdy  (dn_rdy)
            );
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int idx(input int g, input int s);
        return (g - 1) * 2 + s;
    endfunction

    // Reference: exact integer sum, then wrap to 8-bit signed or clamp.
    function automatic int model(input int g, input int s, input logic [127:0] d);
        int sum;
        logic [7:0] b;
        sum = 0;
        for (int k = 0; k < g; k++) begin
            b = d[k*8 +: 8];
            sum += int'($signed(b));
        end
        if (s != 0) begin
            if (sum > 127) return 127;
            if (sum < -128) return -128;
            return sum;
        end
        sum = ((sum % 256) + 256) % 256;
        if (sum > 127) sum -= 256;
        return sum;
    endfunction

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Scoreboard, sampled on the falling edge where inputs and outputs are stable.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                if (rst) begin
                    chk(!dn_val_a[i] && dn_data_a[i] == 8'd0 && up_rdy_a[i],
                        $sformatf("reset_state[%0d]", i),
                        {up_rdy_a[i], dn_val_a[i], dn_data_a[i]}, 10'h200);
                    head[i] = 0; tail[i] = 0;
                    in_cnt[i] = 0; out_cnt[i] = 0;
                    stall_prev[i] = 0;
                end else begin
                    chk(up_rdy_a[i] == !(dn_val_a[i] && !dn_rdy),
                        $sformatf("up_rdy[%0d]", i), up_rdy_a[i], !(dn_val_a[i] && !dn_rdy));
                    if (stall_prev[i]) begin
                        chk(dn_val_a[i] && dn_data_a[i] == held[i],
                            $sformatf("stall_hold[%0d]", i),
                            {dn_val_a[i], dn_data_a[i]}, {1'b1, held[i]});
                    end
                    if (dn_val_a[i]) begin
                        chk(head[i] != tail[i], $sformatf("unexpected_out[%0d]", i),
                            $signed(dn_data_a[i]), tail[i] - head[i]);
                        if (head[i] != tail[i] && dn_rdy) begin
                            chk(int'($signed(dn_data_a[i])) == exp_mem[i][head[i] % 64],
                                $sformatf("data[%0d] beat %0d", i, out_cnt[i]),
                                $signed(dn_data_a[i]), exp_mem[i][head[i] % 64]);
                            head[i]++;
                            out_cnt[i]++;
                            if (collect && i == idx(5, 0) && bp_n < 16) begin
                                bp_out[bp_n] = int'($signed(dn_data_a[i]));
                                bp_n++;
                            end
                        end
                    end
                    if (up_val && up_rdy_a[i]) begin
                        exp_mem[i][tail[i] % 64] = model(i / 2 + 1, i % 2, up_data);
                        tail[i]++;
                        in_cnt[i]++;
                    end
                    stall_prev[i] = dn_val_a[i] && !dn_rdy;
                    held[i]       = dn_data_a[i];
                end
            end
        end
    end

    // Offer one beat from an idle pipeline and record each instance's latency.
    task automatic run_beat(input logic [127:0] d);
        for (int i = 0; i < NI; i++) begin
            lat[i] = -1;
            res[i] = 8'd0;
        end
        up_data = d;
        up_val  = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            up_val = 1'b0;
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                if (lat[i] < 0 && dn_val_a[i]) begin
                    lat[i] = k;
                    res[i] = dn_data_a[i];
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [127:0] d;
        int k;
        int c;
        int pulses;
        bit acc;

        rst = 1'b1; up_val = 1'b0; dn_rdy = 1'b1; up_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // {1,2,3,4,5}
        d = '0;
        for (int b = 0; b < 5; b++) d[b*8 +: 8] = 8'(b + 1);
        chk(model(5, 0, d) == 15, "model_sum15", model(5, 0, d), 15);
        run_beat(d);
        chk(res[idx(5, 0)] == 8'd15, "sum_g5_wrap", res[idx(5, 0)], 15);
        chk(lat[idx(5, 0)] == 5, "lat_g5", lat[idx(5, 0)], 5);
        chk(res[idx(5, 1)] == 8'd15, "sum_g5_sat", res[idx(5, 1)], 15);
        chk(res[idx(1, 0)] == 8'd1, "g1_pass", res[idx(1, 0)], 1);
        chk(lat[idx(1, 0)] == 2, "lat_g1", lat[idx(1, 0)], 2);
        chk(lat[idx(3, 0)] == 4, "lat_g3", lat[idx(3, 0)], 4);
        chk(lat[idx(4, 1)] == 4, "lat_g4", lat[idx(4, 1)], 4);
        chk(lat[idx(8, 0)] == 5, "lat_g8", lat[idx(8, 0)], 5);
        chk(lat[idx(16, 0)] == 6, "lat_g16", lat[idx(16, 0)], 6);

        // 5 x 100
        d = '0;
        for (int b = 0; b < 5; b++) d[b*8 +: 8] = 8'd100;
        chk(model(5, 1, d) == 127, "model_clamp_hi", model(5, 1, d), 127);
        run_beat(d);
        chk(res[idx(5, 0)] == 8'hF4, "ovf_pos_wrap", res[idx(5, 0)], 8'hF4);
        chk(res[idx(5, 1)] == 8'h7F, "ovf_pos_sat", res[idx(5, 1)], 8'h7F);

        // 5 x -100
        d = '0;
        for (int b = 0; b < 5; b++) d[b*8 +: 8] = 8'h9C;
        run_beat(d);
        chk(res[idx(5, 0)] == 8'd12, "ovf_neg_wrap", res[idx(5, 0)], 12);
        chk(res[idx(5, 1)] == 8'h80, "ovf_neg_sat", res[idx(5, 1)], 8'h80);

        // 16 x 0x80
        for (int b = 0; b < 16; b++) d[b*8 +: 8] = 8'h80;
        chk(model(16, 0, d) == 0, "model_g16_wrap", model(16, 0, d), 0);
        run_beat(d);
        chk(res[idx(16, 0)] == 8'h00, "g16_min_wrap", res[idx(16, 0)], 0);
        chk(res[idx(16, 1)] == 8'h80, "g16_min_sat", res[idx(16, 1)], 8'h80);
        chk(res[idx(1, 0)] == 8'h80, "g1_min", res[idx(1, 0)], 8'h80);

        // Reset with three beats in flight and the output stalled.
        for (int b = 0; b < 3; b++) begin
            up_data = {4{32'h0101_0101}} * 128'(b + 2);
            up_val  = 1'b1;
            @(posedge clk);
            #1;
        end
        up_val = 1'b0;
        dn_rdy = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk(up_rdy_a[i] && !dn_val_a[i] && dn_data_a[i] == 8'd0,
                $sformatf("rst_async[%0d]", i),
                {up_rdy_a[i], dn_val_a[i], dn_data_a[i]}, 10'h200);
        end
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        dn_rdy = 1'b1;
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) if (dn_val_a[i]) pulses++;
        end
        chk(pulses == 0, "no_out_after_rst", pulses, 0);
        @(posedge clk);
        #1;

        // Backpressure: sums 1..8 with a three-cycle output stall.
        collect = 1'b1;
        bp_n    = 0;
        k = 1;
        c = 0;
        while (c < 40) begin
            up_val  = (k <= 8);
            up_data = 128'(k);
            dn_rdy  = !(c >= 6 && c < 9);
            @(negedge clk);
            acc = up_val && up_rdy_a[idx(5, 0)];
            @(posedge clk);
            #1;
            if (acc) k++;
            c++;
        end
        up_val  = 1'b0;
        dn_rdy  = 1'b1;
        collect = 1'b0;
        chk(bp_n == 8, "bp_count", bp_n, 8);
        for (int j = 0; j < 8; j++) begin
            chk(bp_out[j] == j + 1, $sformatf("bp_order[%0d]", j), bp_out[j], j + 1);
        end

        // Random traffic, biased towards the extreme operand values.
        for (int cyc = 0; cyc < 20000; cyc++) begin
            up_val = ($urandom_range(0, 9) < 7);
            dn_rdy = ($urandom_range(0, 9) < 7);
            for (int b = 0; b < 16; b++) begin
                case ($urandom_range(0, 3))
                    0:       up_data[b*8 +: 8] = 8'h80;
                    1:       up_data[b*8 +: 8] = 8'h7F;
                    default: up_data[b*8 +: 8] = 8'($urandom_range(0, 255));
                endcase
            end
            @(posedge clk);
            #1;
        end
        up_val = 1'b0;
        dn_rdy = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            chk(in_cnt[i] == out_cnt[i] && in_cnt[i] > 0,
                $sformatf("beat_count[%0d]", i), out_cnt[i], in_cnt[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
